// File: rtl/fixed_point_pkg.sv
// Shared types and helpers for the multi-lane fixed-point accumulator.
package fixed_point_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACCUMULATE,
    ADD_BIAS,
    CONVERT,
    HOLD
  } state_t;

  // Ceiling log2 usable in constant expressions; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = (value > 0) ? value - 1 : 0;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic logic signed [63:0] max_of(input int unsigned width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] min_of(input int unsigned width);
    return -(64'sd1 <<< (width - 1));
  endfunction

  function automatic logic out_of_range(input logic signed [63:0] acc,
                                        input int unsigned       width);
    return (acc > max_of(width)) || (acc < min_of(width));
  endfunction

  // Low `width` bits of the result are the converted value: clamped when
  // saturating, otherwise the plain two's complement wrap of acc.
  function automatic logic [63:0] convert_acc(input logic signed [63:0] acc,
                                              input int unsigned       width,
                                              input bit                saturate);
    if (saturate && (acc > max_of(width))) return max_of(width);
    if (saturate && (acc < min_of(width))) return min_of(width);
    return acc;
  endfunction

endpackage

// File: rtl/fixed_point_acc_mc_lane_adder.sv
// Combinational sign-extending sum of one group of LANES operands at ACC_W bits.
module fixed_point_lane_adder
  import fixed_point_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LANES = 4,
  parameter int unsigned ACC_W = 12
) (
  input  logic [LANES*WIDTH-1:0] lanes,
  input  logic [LANES-1:0]       lane_en,
  output logic signed [ACC_W-1:0] sum
);

  logic signed [WIDTH-1:0] op;

  always_comb begin
    sum = '0;
    op  = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      op = lanes[l*WIDTH +: WIDTH];
      if (lane_en[l]) sum = sum + ACC_W'(op);
    end
  end

endmodule

// File: rtl/fixed_point_acc_mc.sv
// Multi-lane fixed-point accumulator with valid/ready on both sides.
// Build option: FIXED_POINT_ACC_SATURATE_EN clamps out-of-range results instead of wrapping.
module fixed_point_acc_mc
  import fixed_point_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned FRAC_BITS    = 3,
  parameter int unsigned NUM_INPUTS   = 16,
  parameter int unsigned LANES        = 4,
  parameter bit          HAS_EXT_BIAS = 1'b0
) (
  input  logic                        CLK,
  input  logic                        RSTN,
  input  logic [WIDTH*NUM_INPUTS-1:0] VALUES_IN,
  input  logic [WIDTH-1:0]            EXT_VALUE_IN,
  input  logic                        VALID_IN,
  output logic                        READY_OUT,
  output logic [WIDTH-1:0]            VALUE_OUT,
  output logic                        OVERFLOW_OUT,
  output logic                        VALID_OUT,
  input  logic                        READY_IN
);

  localparam int unsigned N_INT = NUM_INPUTS + (HAS_EXT_BIAS ? 1 : 0);
  localparam int unsigned G     = (NUM_INPUTS + LANES - 1) / LANES;
  localparam int unsigned ACC_W = WIDTH + clog2(N_INT);
  localparam int unsigned GW    = (clog2(G) > 0) ? clog2(G) : 1;
  localparam int unsigned PAD_W = G * LANES * WIDTH;
  localparam logic [GW-1:0] LAST_GROUP = GW'(G - 1);

`ifdef FIXED_POINT_ACC_SATURATE_EN
  localparam bit SATURATE = 1'b1;
`else
  localparam bit SATURATE = 1'b0;
`endif

  if (LANES < 1 || LANES > NUM_INPUTS) begin : g_bad_lanes
    $error("LANES must be in 1..NUM_INPUTS");
  end
  if (FRAC_BITS >= WIDTH) begin : g_bad_frac
    $error("FRAC_BITS must be smaller than WIDTH");
  end

  state_t                    state;
  logic [GW-1:0]             group;
  logic signed [ACC_W-1:0]   acc;
  logic [WIDTH*NUM_INPUTS-1:0] values_q;
  logic signed [WIDTH-1:0]   bias_q;
  logic [WIDTH-1:0]          value_q;
  logic                      overflow_q;
  logic                      valid_q;

  logic [PAD_W-1:0]          padded;
  logic [LANES*WIDTH-1:0]    group_ops;
  logic [LANES-1:0]          lane_en;
  logic signed [ACC_W-1:0]   group_sum;

  // Operands are zero-padded up to a whole number of groups; the padding
  // lanes are also masked so they never reach the sum.
  assign padded = PAD_W'(values_q);

  always_comb begin
    group_ops = padded[32'(group)*LANES*WIDTH +: LANES*WIDTH];
    lane_en   = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_en[l] = (32'(group) * LANES + l) < NUM_INPUTS;
    end
  end

  fixed_point_lane_adder #(
    .WIDTH(WIDTH),
    .LANES(LANES),
    .ACC_W(ACC_W)
  ) u_lane_adder (
    .lanes  (group_ops),
    .lane_en(lane_en),
    .sum    (group_sum)
  );

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state      <= IDLE;
      group      <= '0;
      acc        <= '0;
      values_q   <= '0;
      bias_q     <= '0;
      value_q    <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (VALID_IN) begin
            values_q <= VALUES_IN;
            bias_q   <= EXT_VALUE_IN;
            acc      <= '0;
            group    <= '0;
            state    <= ACCUMULATE;
          end
        end
        ACCUMULATE: begin
          acc <= acc + group_sum;
          if (group == LAST_GROUP) begin
            group <= '0;
            state <= HAS_EXT_BIAS ? ADD_BIAS : CONVERT;
          end else begin
            group <= group + 1'b1;
          end
        end
        ADD_BIAS: begin
          acc   <= acc + ACC_W'(bias_q);
          state <= CONVERT;
        end
        CONVERT: begin
          value_q    <= WIDTH'(convert_acc(64'(acc), WIDTH, SATURATE));
          overflow_q <= out_of_range(64'(acc), WIDTH);
          valid_q    <= 1'b1;
          state      <= HOLD;
        end
        HOLD: begin
          if (READY_IN) begin
            valid_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign READY_OUT    = (state == IDLE);
  assign VALUE_OUT    = value_q;
  assign OVERFLOW_OUT = overflow_q;
  assign VALID_OUT    = valid_q;

endmodule

// File: tb/tb_fixed_point_acc_mc.sv
// Directed bench: three accumulator configurations driven from one clock.
module tb_fixed_point_acc_mc;

  logic         clk;
  logic         rstn      [3];
  logic [127:0] values    [3];
  logic [7:0]   ext       [3];
  logic         valid_in  [3];
  logic         ready_out [3];
  logic [7:0]   value_out [3];
  logic         ovf_out   [3];
  logic         valid_out [3];
  logic         ready_in  [3];

  int checks   = 0;
  int failures = 0;

  // d0: 16 inputs, 4 lanes, no bias; d1: same with bias; d2: 10 inputs, 4 lanes.
  fixed_point_acc_mc #(.WIDTH(8), .FRAC_BITS(3), .NUM_INPUTS(16), .LANES(4), .HAS_EXT_BIAS(1'b0)) u_a (
    .CLK(clk), .RSTN(rstn[0]), .VALUES_IN(values[0]), .EXT_VALUE_IN(ext[0]),
    .VALID_IN(valid_in[0]), .READY_OUT(ready_out[0]), .VALUE_OUT(value_out[0]),
    .OVERFLOW_OUT(ovf_out[0]), .VALID_OUT(valid_out[0]), .READY_IN(ready_in[0]));

  fixed_point_acc_mc #(.WIDTH(8), .FRAC_BITS(3), .NUM_INPUTS(16), .LANES(4), .HAS_EXT_BIAS(1'b1)) u_b (
    .CLK(clk), .RSTN(rstn[1]), .VALUES_IN(values[1]), .EXT_VALUE_IN(ext[1]),
    .VALID_IN(valid_in[1]), .READY_OUT(ready_out[1]), .VALUE_OUT(value_out[1]),
    .OVERFLOW_OUT(ovf_out[1]), .VALID_OUT(valid_out[1]), .READY_IN(ready_in[1]));

  fixed_point_acc_mc #(.WIDTH(8), .FRAC_BITS(3), .NUM_INPUTS(10), .LANES(4), .HAS_EXT_BIAS(1'b0)) u_c (
    .CLK(clk), .RSTN(rstn[2]), .VALUES_IN(values[2][79:0]), .EXT_VALUE_IN(ext[2]),
    .VALID_IN(valid_in[2]), .READY_OUT(ready_out[2]), .VALUE_OUT(value_out[2]),
    .OVERFLOW_OUT(ovf_out[2]), .VALID_OUT(valid_out[2]), .READY_IN(ready_in[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called just after a negedge; returns just after the negedge following
  // the edge where VALID_OUT was first seen high (lat = edges after accept).
  task automatic request(input int d, input logic [127:0] after, output int lat);
    check("ready_before_req", 32'(ready_out[d]), 32'd1);
    valid_in[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_in[d] = 1'b0;
    values[d]   = after;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (valid_out[d]) begin
        lat = k;
        break;
      end
    end
  endtask

  function automatic logic [127:0] fill(input logic [7:0] v);
    return {16{v}};
  endfunction

  function automatic logic [127:0] ramp10();
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 10; i++) r[i*8 +: 8] = 8'(i + 1);
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    logic [127:0] v;
    logic [7:0] exp_ovf_val;
`ifdef FIXED_POINT_ACC_SATURATE_EN
    exp_ovf_val = 8'h7F;
`else
    exp_ovf_val = 8'h80;
`endif
    for (int d = 0; d < 3; d++) begin
      rstn[d] = 1'b0; values[d] = '0; ext[d] = '0; valid_in[d] = 1'b0; ready_in[d] = 1'b1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("rst_value", 32'(value_out[d]), 32'h0);
      check("rst_ovf", 32'(ovf_out[d]), 32'h0);
      check("rst_valid", 32'(valid_out[d]), 32'h0);
      check("rst_ready", 32'(ready_out[d]), 32'h1);
      rstn[d] = 1'b1;
    end
    @(negedge clk);

    // 16 x 0.5 = 8.0, one-cycle VALID_OUT with READY_IN held high
    values[0] = fill(8'h04);
    request(0, fill(8'h04), lat);
    check("t1_lat", 32'(lat), 32'd5);
    check("t1_value", 32'(value_out[0]), 32'h40);
    check("t1_ovf", 32'(ovf_out[0]), 32'h0);
    @(posedge clk); @(negedge clk);
    check("t1_valid_width", 32'(valid_out[0]), 32'h0);
    check("t1_ready_back", 32'(ready_out[0]), 32'h1);

    // 16 x 1.0 = 128 -> just past the positive limit
    values[0] = fill(8'h08);
    request(0, fill(8'h08), lat);
    check("t2_lat", 32'(lat), 32'd5);
    check("t2_value", 32'(value_out[0]), 32'(exp_ovf_val));
    check("t2_ovf", 32'(ovf_out[0]), 32'h1);
    @(posedge clk); @(negedge clk);

    // 16 x -1.0 = -128 -> exact minimum
    values[0] = fill(8'hF8);
    request(0, fill(8'hF8), lat);
    check("t3_value", 32'(value_out[0]), 32'h80);
    check("t3_ovf", 32'(ovf_out[0]), 32'h0);
    @(posedge clk); @(negedge clk);

    // 15 x 8 + 7 = 127 -> exact maximum
    v = fill(8'h08);
    v[127:120] = 8'h07;
    values[0] = v;
    request(0, v, lat);
    check("tmax_value", 32'(value_out[0]), 32'h7F);
    check("tmax_ovf", 32'(ovf_out[0]), 32'h0);
    @(posedge clk); @(negedge clk);

    // bias: 8.0 + -2.0 = 6.0; inputs scrambled after accept
    values[1] = fill(8'h04);
    ext[1] = 8'hF0;
    request(1, fill(8'h7F), lat);
    ext[1] = 8'h7F;
    check("t4_lat", 32'(lat), 32'd6);
    check("t4_value", 32'(value_out[1]), 32'h30);
    check("t4_ovf", 32'(ovf_out[1]), 32'h0);
    @(posedge clk); @(negedge clk);
    check("t4_valid_width", 32'(valid_out[1]), 32'h0);

    // backpressure: result must be held while VALID_IN pulses
    ready_in[0] = 1'b0;
    values[0] = fill(8'h04);
    request(0, fill(8'h04), lat);
    check("t5_lat", 32'(lat), 32'd5);
    for (int i = 0; i < 10; i++) begin
      valid_in[0] = i[0];
      values[0] = fill(8'h7F);
      @(posedge clk); @(negedge clk);
      check("t5_hold_valid", 32'(valid_out[0]), 32'h1);
      check("t5_hold_value", 32'(value_out[0]), 32'h40);
      check("t5_hold_ready", 32'(ready_out[0]), 32'h0);
    end
    valid_in[0] = 1'b0;
    ready_in[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    check("t5_release_valid", 32'(valid_out[0]), 32'h0);
    check("t5_release_ready", 32'(ready_out[0]), 32'h1);
    values[0] = fill(8'hFC);
    request(0, fill(8'hFC), lat);
    check("t5_next_lat", 32'(lat), 32'd5);
    check("t5_next_value", 32'(value_out[0]), 32'hC0);
    @(posedge clk); @(negedge clk);

    // 10 inputs, 4 lanes: tail padding, 1+..+10 = 55
    values[2] = ramp10();
    request(2, ramp10(), lat);
    check("t6_lat", 32'(lat), 32'd4);
    check("t6_value", 32'(value_out[2]), 32'h37);
    check("t6_ovf", 32'(ovf_out[2]), 32'h0);
    @(posedge clk); @(negedge clk);

    // reset in the middle of ACCUMULATE
    check("t6r_ready", 32'(ready_out[2]), 32'h1);
    valid_in[2] = 1'b1;
    @(posedge clk); @(negedge clk);
    valid_in[2] = 1'b0;
    @(posedge clk); @(negedge clk);
    check("t6r_busy", 32'(ready_out[2]), 32'h0);
    rstn[2] = 1'b0;
    @(posedge clk); @(negedge clk);
    check("t6r_value", 32'(value_out[2]), 32'h0);
    check("t6r_ovf", 32'(ovf_out[2]), 32'h0);
    check("t6r_valid", 32'(valid_out[2]), 32'h0);
    rstn[2] = 1'b1;
    @(posedge clk); @(negedge clk);
    check("t6r_ready_after", 32'(ready_out[2]), 32'h1);
    check("t6r_no_valid", 32'(valid_out[2]), 32'h0);
    request(2, ramp10(), lat);
    check("t6r_lat", 32'(lat), 32'd4);
    check("t6r_value_again", 32'(value_out[2]), 32'h37);
    @(posedge clk); @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
